mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter: DEPTH, default 4, max outstanding accepted-but-unanswered requests (power of 2, 2..16).
REQ-002 Ports: clk  in  1  sole clock, all state on posedge.
REQ-003 Ports: reset  in  1  synchronous, active-high.
REQ-004 Ports: inst_req/inst_wr  in  1/1, inst_size  in  2, inst_addr  in  32, inst_wstrb  in  4, inst_wdata  in  32  fetch-side SRAM-like request.
REQ-005 Ports: inst_addr_ok/inst_data_ok  out  1/1, inst_rdata  out  32  fetch-side responses.
REQ-006 Ports: data_req/data_wr  in  1/1, data_size  in  2, data_addr  in  32, data_wstrb  in  4, data_wdata  in  32  EX-stage request.
REQ-007 Ports: data_addr_ok/data_data_ok  out  1/1, data_rdata  out  32  EX/MEM-side responses.
REQ-008 Ports: mem_req/mem_wr  out  1/1, mem_size  out  2, mem_addr  out  32, mem_wstrb  out  4, mem_wdata  out  32  shared downstream request.
REQ-009 Ports: mem_addr_ok/mem_data_ok  in  1/1, mem_rdata  in  32  shared downstream responses.
REQ-010 Ports: arb_full  out  1  owner FIFO holds DEPTH entries.

Function
REQ-011 Handshake: request accepted in a cycle iff mem_req & mem_addr_ok; response returned iff mem_data_ok; responses return in acceptance order.
REQ-012 Grant: when unlocked and FIFO not full, grant = data if data_req, else inst if inst_req, else none (fixed priority, data wins).
REQ-013 Lock: mem_req=1 & mem_addr_ok=0 sets lock to current grantee; next cycles grant held to that owner regardless of other requests until accept; lock clears in accept cycle.
REQ-014 While locked, a grantee deasserting its req drops mem_req that cycle and clears lock (cancel tolerated, no FIFO push).
REQ-015 mem_* request fields = combinational mux of grantee fields; all zero when no grant; mem_req = grantee req & ~arb_full.
REQ-016 addr_ok routing: inst_addr_ok = mem_addr_ok & mem_req & grant==inst; data_addr_ok likewise; non-grantee addr_ok = 0.
REQ-017 Owner FIFO: DEPTH entries x 1 bit (0=inst,1=data), head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
REQ-018 Push owner on accept; pop head on mem_data_ok with count>0; simultaneous push+pop -> count unchanged, both pointers advance.
REQ-019 data_ok routing: mem_data_ok & count>0 -> data_ok to head owner only; rdata to both sides = mem_rdata unconditionally.
REQ-020 mem_data_ok with count==0: ignored, no data_ok emitted, no state change.
REQ-021 arb_full = (count==DEPTH); when full mem_req=0 and both addr_ok=0; a pop in full cycle lets a request be accepted next cycle, not same cycle.
REQ-022 Latency: zero-cycle combinational pass of req->mem_req, addr_ok, data_ok; no added pipeline registers.

Reset
REQ-023 reset=1 at posedge: count=0, head=tail=0, lock cleared, RR pointer=data-preferred (if compiled).
REQ-024 During and first cycle after reset: mem_req=0, all addr_ok/data_ok=0, arb_full=0; in-flight owners discarded, later mem_data_ok ignored per REQ-020.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: unlocked grant by round-robin; 1-bit last_winner register updated on each accept; on contention, side other than last_winner wins.
REQ-026 Macro undefined: fixed priority per REQ-012; no last_winner register.

Verification
REQ-027 Both req=1, mem_addr_ok=1, fixed-priority build -> data_addr_ok=1, inst_addr_ok=0, FIFO pushes 1.
REQ-028 data_req=1, mem_addr_ok=0 for 3 cycles, inst_req=1 throughout -> mem_addr = data_addr all 4 cycles; 4th cycle addr_ok=1 -> data accepted; cycle 5 inst granted.
REQ-029 Accept inst, data, inst (DEPTH=4); three mem_data_ok with rdata 0x11,0x22,0x33 -> inst_data_ok, data_data_ok, inst_data_ok in order, rdata values match.
REQ-030 Four accepts without data_ok -> arb_full=1, mem_req=0 despite data_req=1; one mem_data_ok -> arb_full=0 next cycle, request accepted.
REQ-031 mem_data_ok=1 with empty FIFO, and reset asserted mid-stream with 2 outstanding -> no data_ok pulses, count=0 after reset.
REQ-032 MEM_ARB_RR_EN, both req held, mem_addr_ok=1 for 4 cycles -> grants alternate data, inst, data, inst.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-master (fetch/data) arbiter onto one SRAM-like port, with an owner FIFO that routes in-order responses.
// Build option MEM_ARB_RR_EN: round-robin unlocked grant instead of fixed data-first priority.
module mem_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'b00,
    LOCK_INST = 2'b01,
    LOCK_DATA = 2'b10
  } lock_e;

  lock_e             lock_state_r;
  lock_e             lock_state_s;
  logic [DEPTH-1:0]  owner_mem_r;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              quiet_r;
  logic              blocked_s;
  logic              full_s;
  logic              gnt_valid_s;
  logic              gnt_owner_s;
  logic              gnt_req_s;
  logic              accept_s;
  logic              pop_s;

  // Outputs stay silent while reset is high and for one cycle after it drops.
  assign blocked_s = reset | quiet_r;
  assign full_s    = (count_r == CNT_W'(DEPTH));

`ifdef MEM_ARB_RR_EN
  logic last_winner_r;

  // Remembers who won the last accepted request; reset makes data the preferred side.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_r <= OWN_INST;
    end else if (accept_s) begin
      last_winner_r <= gnt_owner_s;
    end else begin
      last_winner_r <= last_winner_r;
    end
  end
`endif

  // Grant selection: a stalled request keeps its owner, otherwise arbitrate when there is FIFO room.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_owner_s = OWN_INST;
    case (lock_state_r)
      LOCK_INST: begin
        gnt_valid_s = 1'b1;
        gnt_owner_s = OWN_INST;
      end
      LOCK_DATA: begin
        gnt_valid_s = 1'b1;
        gnt_owner_s = OWN_DATA;
      end
      default: begin
        if (!full_s) begin
`ifdef MEM_ARB_RR_EN
          if (data_req && inst_req) begin
            gnt_valid_s = 1'b1;
            gnt_owner_s = ~last_winner_r;
          end else if (data_req) begin
            gnt_valid_s = 1'b1;
            gnt_owner_s = OWN_DATA;
          end else if (inst_req) begin
            gnt_valid_s = 1'b1;
            gnt_owner_s = OWN_INST;
          end else begin
            gnt_valid_s = 1'b0;
          end
`else
          if (data_req) begin
            gnt_valid_s = 1'b1;
            gnt_owner_s = OWN_DATA;
          end else if (inst_req) begin
            gnt_valid_s = 1'b1;
            gnt_owner_s = OWN_INST;
          end else begin
            gnt_valid_s = 1'b0;
          end
`endif
        end else begin
          gnt_valid_s = 1'b0;
        end
      end
    endcase
  end

  assign gnt_req_s = gnt_owner_s ? data_req : inst_req;
  assign mem_req   = gnt_valid_s & gnt_req_s & ~full_s & ~blocked_s;
  assign accept_s  = mem_req & mem_addr_ok;
  assign pop_s     = mem_data_ok & (count_r != CNT_W'(0)) & ~blocked_s;

  // Downstream request fields follow the grantee; zero when nobody holds the grant.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = 32'h0000_0000;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'h0000_0000;
    if (gnt_valid_s && !blocked_s) begin
      if (gnt_owner_s == OWN_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
      end
    end else begin
      mem_wr = 1'b0;
    end
  end

  assign inst_addr_ok = accept_s & (gnt_owner_s == OWN_INST);
  assign data_addr_ok = accept_s & (gnt_owner_s == OWN_DATA);
  assign inst_data_ok = pop_s & (owner_mem_r[head_r] == OWN_INST);
  assign data_data_ok = pop_s & (owner_mem_r[head_r] == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_full     = full_s & ~blocked_s;

  // Lock next state: a presented-but-refused request pins the grant; a dropped req cancels it.
  always_comb begin
    lock_state_s = LOCK_NONE;
    if (mem_req && !mem_addr_ok) begin
      lock_state_s = (gnt_owner_s == OWN_DATA) ? LOCK_DATA : LOCK_INST;
    end else begin
      lock_state_s = LOCK_NONE;
    end
  end

  // Lock state register and post-reset quiet flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state_r <= LOCK_NONE;
      quiet_r      <= 1'b1;
    end else begin
      lock_state_r <= lock_state_s;
      quiet_r      <= 1'b0;
    end
  end

  // Owner FIFO: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_mem_r <= '0;
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
    end else begin
      if (accept_s) begin
        owner_mem_r[tail_r] <= gnt_owner_s;
        tail_r              <= tail_r + PTR_W'(1);
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end else begin
        head_r <= head_r;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter against a queue-based reference model; honours MEM_ARB_RR_EN.
module tb_mem_req_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_wstrb;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, arb_full;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_full(arb_full)
  );

  int checks = 0;
  int errors = 0;
  int own_q[$];     // owners of accepted, unanswered requests (0=inst, 1=data)
  int pend   = -1;  // owner of a refused request that keeps the grant
  int last_w = 0;   // last accepted side; 0 means data is preferred next
  bit quiet  = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wstrb = 4'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wstrb = 4'd0; data_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0; reset = 1'b0;
  endtask

  task automatic rand_inputs(input int p_req, input int p_aok, input int p_dok, input int p_rst);
    inst_req   = ($urandom_range(99) < p_req);
    inst_wr    = 1'($urandom);
    inst_size  = 2'($urandom);
    inst_addr  = $urandom;
    inst_wstrb = 4'($urandom);
    inst_wdata = $urandom;
    data_req   = ($urandom_range(99) < p_req);
    data_wr    = 1'($urandom);
    data_size  = 2'($urandom);
    data_addr  = $urandom;
    data_wstrb = 4'($urandom);
    data_wdata = $urandom;
    mem_addr_ok = ($urandom_range(99) < p_aok);
    mem_data_ok = ($urandom_range(99) < p_dok);
    mem_rdata   = $urandom;
    reset       = ($urandom_range(999) < p_rst);
  endtask

  // Compare DUT against the model for the current input set, then advance the model.
  task automatic eval_cycle();
    int g;
    bit blk, full, e_req, e_pop, e_di, e_dd;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    blk  = reset || quiet;
    full = (own_q.size() == DEPTH);
    g = -1;
    if (pend >= 0) g = pend;
    else if (!full) begin
`ifdef MEM_ARB_RR_EN
      if (inst_req && data_req) g = (last_w == 1) ? 0 : 1;
      else if (data_req) g = 1;
      else if (inst_req) g = 0;
`else
      if (data_req) g = 1;
      else if (inst_req) g = 0;
`endif
    end
    if (blk) g = -1;
    e_req = (g == 1) ? data_req : (g == 0) ? inst_req : 1'b0;
    e_req = e_req && !full;
    e_wr = 1'b0; e_size = 2'd0; e_addr = 32'd0; e_wstrb = 4'd0; e_wdata = 32'd0;
    if (g == 1) begin
      e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wstrb = data_wstrb; e_wdata = data_wdata;
    end else if (g == 0) begin
      e_wr = inst_wr; e_size = inst_size; e_addr = inst_addr; e_wstrb = inst_wstrb; e_wdata = inst_wdata;
    end
    e_pop = mem_data_ok && (own_q.size() > 0) && !blk;
    e_di  = e_pop && (own_q[0] == 0);
    e_dd  = e_pop && (own_q[0] == 1);

    check_val("mem_req", 32'(mem_req), 32'(e_req));
    check_val("mem_wr", 32'(mem_wr), 32'(e_wr));
    check_val("mem_size", 32'(mem_size), 32'(e_size));
    check_val("mem_addr", mem_addr, e_addr);
    check_val("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
    check_val("mem_wdata", mem_wdata, e_wdata);
    check_val("inst_addr_ok", 32'(inst_addr_ok), 32'(e_req && mem_addr_ok && g == 0));
    check_val("data_addr_ok", 32'(data_addr_ok), 32'(e_req && mem_addr_ok && g == 1));
    check_val("inst_data_ok", 32'(inst_data_ok), 32'(e_di));
    check_val("data_data_ok", 32'(data_data_ok), 32'(e_dd));
    check_val("inst_rdata", inst_rdata, mem_rdata);
    check_val("data_rdata", data_rdata, mem_rdata);
    check_val("arb_full", 32'(arb_full), 32'(full && !blk));

    if (reset) begin
      own_q.delete();
      pend = -1; last_w = 0; quiet = 1'b1;
    end else begin
      quiet = 1'b0;
      if (e_pop) void'(own_q.pop_front());
      if (e_req && mem_addr_ok) begin
        own_q.push_back(g);
        last_w = g;
      end
      pend = (e_req && !mem_addr_ok) ? g : -1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Reset held with live requests: outputs must stay quiet.
    for (int i = 0; i < 2; i++) begin
      rand_inputs(90, 80, 50, 0);
      reset = 1'b1;
      step();
    end
    clear_inputs();
    step();

    // Contention with immediate accept, then a stalled data request while inst waits.
    clear_inputs(); inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1000; data_addr = 32'h2000; mem_addr_ok = 1'b1;
    step();
    clear_inputs(); mem_data_ok = 1'b1; mem_rdata = 32'h0000_00aa;
    step();
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1000; data_addr = 32'h2000;
      mem_addr_ok = (i >= 3);
      step();
    end
    // Drain, then inst/data/inst ordering with distinct response data.
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); mem_data_ok = 1'b1; mem_rdata = 32'h11 * (i + 1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); inst_req = (i != 1); data_req = (i == 1); mem_addr_ok = 1'b1;
      inst_addr = 32'h100 + i; data_addr = 32'h200 + i;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); mem_data_ok = 1'b1; mem_rdata = 32'h11 * (i + 1);
      step();
    end
    // Fill to full, hold data_req, release one slot.
    for (int i = 0; i < 6; i++) begin
      clear_inputs(); data_req = 1'b1; data_addr = 32'h3000 + i; mem_addr_ok = 1'b1;
      mem_data_ok = (i == 4);
      step();
    end
    // Empty-FIFO response, and reset with requests outstanding.
    clear_inputs(); mem_data_ok = 1'b1;
    step();
    clear_inputs(); reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); mem_data_ok = 1'b1; mem_rdata = 32'h5a5a_0000 + i;
      step();
    end

    // Random phases with varied back-pressure and occasional resets.
    for (int i = 0; i < 800; i++) begin rand_inputs(70, 50, 40, 5); step(); end
    for (int i = 0; i < 800; i++) begin rand_inputs(90, 30, 15, 2); step(); end
    for (int i = 0; i < 800; i++) begin rand_inputs(50, 80, 70, 10); step(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
